ysyx_rsu: RTL and testbench
===========================

Name: ysyx_rsu

Overview:
- Reservation-station execution unit: the responder end of the dispatch/result protocol between the issue queue/ROB and execute.
- Accepts dispatched micro-ops carrying operand values or ROB tags (qj/qk), and snoops result broadcasts until both operands are ready.
- Issues the lowest-index ready entry to an integer ALU/branch datapath, then returns the registered result to the ROB tagged with its dest.

Parameters:
- XLEN, 32, datapath width.
- RS_SIZE, 4, number of reservation-station entries.
- ROB_SIZE, 8, ROB depth. TAG_W = $clog2(ROB_SIZE)+1. Tag 0 means operand ready; dest/qj/qk carry ROB index + 1.

Ports:
- clock  in  1  clock.
- reset  in  1  synchronous, active-low reset (reset==0 resets on the clock edge).
- flush  in  1  pipeline flush from commit.
- in_valid  in  1  dispatch request.
- out_ready  out  1  at least one free entry.
- in_alu_op  in  5  op: {bit3=sub/sra, bits2:0=funct3}; for branches bits2:0 = branch funct3.
- in_jen / in_ben  in  1 each  jump / conditional branch.
- in_op1, in_op2, in_imm, in_pc  in  XLEN each  operand values (valid when tag is 0), immediate, pc.
- in_qj, in_qk, in_dest  in  TAG_W each  source tags, destination tag.
- cdb_valid  in  1  external result broadcast (e.g. LSU).
- cdb_dest  in  TAG_W  broadcast tag.
- cdb_result  in  XLEN  broadcast value.
- wb_valid  out  1  result valid (one-cycle pulse per op).
- wb_dest  out  TAG_W  result tag.
- wb_result  out  XLEN  rd value.
- wb_npc  out  XLEN  next pc.
- wb_pc_change  out  1  taken branch or jump.

Behaviour:
- Reset (reset==0) or flush: all entries invalid, wb_valid=0, wb_dest=0, wb_result=0, wb_npc=0, wb_pc_change=0. Flush wins over a dispatch, an issue or a broadcast in the same cycle.
- out_ready is combinational: it is 1 iff some entry is invalid in the current state. An entry freed by an issue in cycle T can be reallocated in T+1 at the earliest.
- Dispatch (in_valid && out_ready): write the lowest-index free entry. Setting in_valid without out_ready is ignored, with no state change.
- Wakeup sources, all same cycle: the external CDB (cdb_valid) and this block's own wb port (wb_valid/wb_dest/wb_result).
  - A waiting entry with qj==broadcast tag (tag≠0) latches the value into op1 and sets qj=0; qk/op2 likewise. Both may match the same broadcast.
  - If both sources carry the same nonzero tag in one cycle, the CDB value wins.
- Dispatch bypass: if an incoming qj/qk equals a same-cycle broadcast tag, the entry is stored with the value and tag 0. Without this the operand would be lost.
- Issue: in cycle T, select the lowest-index valid entry with qj==0 and qk==0, as seen at the start of T.
  - Compute its result combinationally, register it into the wb_* outputs, and set wb_valid=1 in T+1. The entry is freed at the end of T.
  - One issue per cycle. When nothing is selected, wb_valid=0 in T+1.
- Latency:
  - An op dispatched ready in T issues in T+1; wb_valid is high in T+2.
  - An op woken by a broadcast in T issues in T+1.
- ALU results are mod 2^XLEN; shift amount is op2[4:0].
  - 0 ADD, 8 SUB, 1 SLL, 2 SLT, 3 SLTU, 4 XOR, 5 SRL, 13 SRA, 6 OR, 7 AND.
  - Non-control ops: npc=pc+4, pc_change=0.
- ben: compare op1 vs op2 on funct3: 0 EQ, 1 NE, 4 LT, 5 GE, 6 LTU, 7 GEU.
  - Taken: npc=pc+imm, pc_change=1. Not taken: npc=pc+4, pc_change=0.
  - result=0.
- jen: result=pc+4, npc=(op1+imm)&~1, pc_change=1. The IDU supplies op1=pc for JAL.
- Tag 0 in cdb_dest, or on the own wb port, never wakes anything.
- A dest tag is unique among in-flight ops; the block does not check this.

Test Plan:
- Ready ADD: dispatch in cycle 0 with op1=5, op2=7, qj=qk=0, dest=3 → wb_valid only in cycle 2, wb_dest=3, wb_result=12, wb_npc=pc+4, wb_pc_change=0.
- Wakeup: dispatch SUB (op 8) with qj=2, op2=1, dest=4 in cycle 0; CDB dest=2, result=10 in cycle 3 → wb_valid in cycle 5, wb_result=9. Same flow with the CDB asserted in the dispatch cycle (bypass) → wb_valid in cycle 2, result 9.
- Chained own-forwarding: ADD dest=1 (5+7) dispatched in cycle 0, then XOR qj=1, op2=0xF, dest=2 in cycle 1 → wb dest=1 result 12 in cycle 2, wb dest=2 result 3 in cycle 4.
- Full/select: fill 4 entries waiting on tag 5 → out_ready=0 and a 5th in_valid is ignored. CDB dest=5 → the entries issue in index order on consecutive cycles, and out_ready=1 the cycle after the first issue.
- Branch/jump: BNE (op 1) with op1=1, op2=2, pc=0x100, imm=0x20 → npc=0x120, pc_change=1. BEQ with the same operands → npc=0x104, pc_change=0. JALR with op1=0x203, imm=0 → result=pc+4, npc=0x202.
- Flush/reset: flush asserted with 3 entries valid and one op in the wb register → next cycle wb_valid=0, out_ready=1, and no later wb_valid for those ops. Driving reset=0 for one cycle mid-run gives the same effect.

Source files
------------

// File: rtl/ysyx_rsu_if.sv
// Dispatch, result-broadcast and write-back bundle between the issue side and the RSU.
// master = issue queue / ROB side, slave = reservation-station unit.
interface ysyx_rsu_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             out_ready;
    logic [4:0]       in_alu_op;
    logic             in_jen;
    logic             in_ben;
    logic [XLEN-1:0]  in_op1;
    logic [XLEN-1:0]  in_op2;
    logic [XLEN-1:0]  in_imm;
    logic [XLEN-1:0]  in_pc;
    logic [TAG_W-1:0] in_qj;
    logic [TAG_W-1:0] in_qk;
    logic [TAG_W-1:0] in_dest;

    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_dest;
    logic [XLEN-1:0]  cdb_result;

    logic             wb_valid;
    logic [TAG_W-1:0] wb_dest;
    logic [XLEN-1:0]  wb_result;
    logic [XLEN-1:0]  wb_npc;
    logic             wb_pc_change;

    modport master (
        output in_valid, in_alu_op, in_jen, in_ben, in_op1, in_op2, in_imm, in_pc,
               in_qj, in_qk, in_dest, cdb_valid, cdb_dest, cdb_result,
        input  out_ready, wb_valid, wb_dest, wb_result, wb_npc, wb_pc_change
    );

    modport slave (
        input  in_valid, in_alu_op, in_jen, in_ben, in_op1, in_op2, in_imm, in_pc,
               in_qj, in_qk, in_dest, cdb_valid, cdb_dest, cdb_result,
        output out_ready, wb_valid, wb_dest, wb_result, wb_npc, wb_pc_change
    );
endinterface

// File: rtl/ysyx_rsu.sv
// Reservation-station unit: holds dispatched ops until both operands are ready, then
// issues the lowest-index ready entry to an ALU/branch datapath with a registered write-back.
module ysyx_rsu #(
    parameter int XLEN     = 32,
    parameter int RS_SIZE  = 4,
    parameter int ROB_SIZE = 8
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      flush,
    ysyx_rsu_if.slave bus
);
    localparam int TAG_W = $clog2(ROB_SIZE) + 1;
    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [XLEN-1:0]  word_t;
    typedef logic [IDX_W-1:0] idx_t;

    logic       r_valid [RS_SIZE];
    logic [3:0] r_op    [RS_SIZE];
    logic       r_jen   [RS_SIZE];
    logic       r_ben   [RS_SIZE];
    word_t      r_op1   [RS_SIZE];
    word_t      r_op2   [RS_SIZE];
    word_t      r_imm   [RS_SIZE];
    word_t      r_pc    [RS_SIZE];
    tag_t       r_qj    [RS_SIZE];
    tag_t       r_qk    [RS_SIZE];
    tag_t       r_dest  [RS_SIZE];

    logic  r_wb_valid;
    tag_t  r_wb_dest;
    word_t r_wb_result;
    word_t r_wb_npc;
    logic  r_wb_pc_change;

    logic  w_free_found, w_iss_found;
    idx_t  w_free_idx, w_iss_idx;
    logic  w_cdb_hit, w_own_hit;
    logic  w_j_hit [RS_SIZE];
    logic  w_k_hit [RS_SIZE];
    word_t w_j_val [RS_SIZE];
    word_t w_k_val [RS_SIZE];
    logic  w_dj_hit, w_dk_hit;
    word_t w_dj_val, w_dk_val;
    logic  w_unused_op;

    logic [3:0] w_opc;
    logic       w_jen, w_ben, w_taken;
    word_t      w_a, w_b, w_imm, w_pc, w_seq_pc, w_sra, w_alu;
    word_t      w_ex_result, w_ex_npc;
    logic       w_ex_pc_change;

    assign w_unused_op = bus.in_alu_op[4];

    // Tag 0 means "ready" and must never be treated as a broadcast match.
    assign w_cdb_hit = bus.cdb_valid && (bus.cdb_dest != '0);
    assign w_own_hit = r_wb_valid && (r_wb_dest != '0);

    function automatic logic snoop_hit(input tag_t tag, input logic cdb_hit, input tag_t cdb_tag,
                                       input logic own_hit, input tag_t own_tag);
        return (tag != '0) && ((cdb_hit && (tag == cdb_tag)) || (own_hit && (tag == own_tag)));
    endfunction

    // CDB takes priority over the own write-back when both carry the same tag.
    function automatic word_t snoop_val(input tag_t tag, input logic cdb_hit, input tag_t cdb_tag,
                                        input word_t cdb_val, input word_t own_val);
        return (cdb_hit && (tag == cdb_tag)) ? cdb_val : own_val;
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            w_j_hit[i] = snoop_hit(r_qj[i], w_cdb_hit, bus.cdb_dest, w_own_hit, r_wb_dest);
            w_k_hit[i] = snoop_hit(r_qk[i], w_cdb_hit, bus.cdb_dest, w_own_hit, r_wb_dest);
            w_j_val[i] = snoop_val(r_qj[i], w_cdb_hit, bus.cdb_dest, bus.cdb_result, r_wb_result);
            w_k_val[i] = snoop_val(r_qk[i], w_cdb_hit, bus.cdb_dest, bus.cdb_result, r_wb_result);
        end
        w_dj_hit = snoop_hit(bus.in_qj, w_cdb_hit, bus.cdb_dest, w_own_hit, r_wb_dest);
        w_dk_hit = snoop_hit(bus.in_qk, w_cdb_hit, bus.cdb_dest, w_own_hit, r_wb_dest);
        w_dj_val = snoop_val(bus.in_qj, w_cdb_hit, bus.cdb_dest, bus.cdb_result, r_wb_result);
        w_dk_val = snoop_val(bus.in_qk, w_cdb_hit, bus.cdb_dest, bus.cdb_result, r_wb_result);
    end

    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        w_iss_found  = 1'b0;
        w_iss_idx    = '0;
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            if (!r_valid[i] && !w_free_found) begin
                w_free_found = 1'b1;
                w_free_idx   = idx_t'(i);
            end
            if (r_valid[i] && (r_qj[i] == '0) && (r_qk[i] == '0) && !w_iss_found) begin
                w_iss_found = 1'b1;
                w_iss_idx   = idx_t'(i);
            end
        end
    end

    assign bus.out_ready = w_free_found;

    always_comb begin
        w_opc    = r_op[w_iss_idx];
        w_jen    = r_jen[w_iss_idx];
        w_ben    = r_ben[w_iss_idx];
        w_a      = r_op1[w_iss_idx];
        w_b      = r_op2[w_iss_idx];
        w_imm    = r_imm[w_iss_idx];
        w_pc     = r_pc[w_iss_idx];
        w_seq_pc = w_pc + word_t'(4);
        w_sra    = $signed(w_a) >>> w_b[4:0];

        case (w_opc[2:0])
            3'd0:    w_alu = w_opc[3] ? (w_a - w_b) : (w_a + w_b);
            3'd1:    w_alu = w_a << w_b[4:0];
            3'd2:    w_alu = {{(XLEN-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
            3'd3:    w_alu = {{(XLEN-1){1'b0}}, (w_a < w_b)};
            3'd4:    w_alu = w_a ^ w_b;
            3'd5:    w_alu = w_opc[3] ? w_sra : (w_a >> w_b[4:0]);
            3'd6:    w_alu = w_a | w_b;
            default: w_alu = w_a & w_b;
        endcase

        case (w_opc[2:0])
            3'd0:    w_taken = (w_a == w_b);
            3'd1:    w_taken = (w_a != w_b);
            3'd4:    w_taken = ($signed(w_a) < $signed(w_b));
            3'd5:    w_taken = ($signed(w_a) >= $signed(w_b));
            3'd6:    w_taken = (w_a < w_b);
            3'd7:    w_taken = (w_a >= w_b);
            default: w_taken = 1'b0;
        endcase

        if (w_jen) begin
            w_ex_result    = w_seq_pc;
            w_ex_npc       = (w_a + w_imm) & ~word_t'(1);
            w_ex_pc_change = 1'b1;
        end else if (w_ben) begin
            w_ex_result    = '0;
            w_ex_npc       = w_taken ? (w_pc + w_imm) : w_seq_pc;
            w_ex_pc_change = w_taken;
        end else begin
            w_ex_result    = w_alu;
            w_ex_npc       = w_seq_pc;
            w_ex_pc_change = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset || flush) begin
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                r_valid[i] <= 1'b0;
            end
            r_wb_valid     <= 1'b0;
            r_wb_dest      <= '0;
            r_wb_result    <= '0;
            r_wb_npc       <= '0;
            r_wb_pc_change <= 1'b0;
        end else begin
            r_wb_valid <= w_iss_found;
            if (w_iss_found) begin
                r_wb_dest      <= r_dest[w_iss_idx];
                r_wb_result    <= w_ex_result;
                r_wb_npc       <= w_ex_npc;
                r_wb_pc_change <= w_ex_pc_change;
            end

            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                if (w_iss_found && (w_iss_idx == idx_t'(i))) begin
                    r_valid[i] <= 1'b0;
                end
                if (r_valid[i] && w_j_hit[i]) begin
                    r_op1[i] <= w_j_val[i];
                    r_qj[i]  <= '0;
                end
                if (r_valid[i] && w_k_hit[i]) begin
                    r_op2[i] <= w_k_val[i];
                    r_qk[i]  <= '0;
                end
            end

            // The target slot is currently invalid, so it never collides with the issue/wakeup updates above.
            if (bus.in_valid && w_free_found) begin
                r_valid[w_free_idx] <= 1'b1;
                r_op[w_free_idx]    <= bus.in_alu_op[3:0];
                r_jen[w_free_idx]   <= bus.in_jen;
                r_ben[w_free_idx]   <= bus.in_ben;
                r_imm[w_free_idx]   <= bus.in_imm;
                r_pc[w_free_idx]    <= bus.in_pc;
                r_dest[w_free_idx]  <= bus.in_dest;
                r_op1[w_free_idx]   <= w_dj_hit ? w_dj_val : bus.in_op1;
                r_qj[w_free_idx]    <= w_dj_hit ? '0 : bus.in_qj;
                r_op2[w_free_idx]   <= w_dk_hit ? w_dk_val : bus.in_op2;
                r_qk[w_free_idx]    <= w_dk_hit ? '0 : bus.in_qk;
            end
        end
    end

    assign bus.wb_valid     = r_wb_valid;
    assign bus.wb_dest      = r_wb_dest;
    assign bus.wb_result    = r_wb_result;
    assign bus.wb_npc       = r_wb_npc;
    assign bus.wb_pc_change = r_wb_pc_change;
endmodule

// File: tb/tb_ysyx_rsu.sv
// Bench for ysyx_rsu: vector table of ready ops plus hand-written wakeup/full/flush sequences,
// with a write-back scoreboard that also checks the cycle each result appears.
module tb_ysyx_rsu;
    localparam int XLEN  = 32;
    localparam int TAG_W = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    ysyx_rsu_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    ysyx_rsu #(.XLEN(XLEN), .RS_SIZE(4), .ROB_SIZE(8)) dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [TAG_W-1:0] dest;
        logic [31:0]      res;
        logic [31:0]      npc;
        logic             chg;
        int               cyc;
    } exp_t;

    typedef struct {
        logic [4:0]  op;
        logic        jen;
        logic        ben;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] res;
        logic [31:0] npc;
        logic        chg;
    } vec_t;

    exp_t sb[$];
    vec_t vt[$];

    always @(negedge clock) begin
        exp_t e;
        if (bus.wb_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: cycle %0d got dest=%0d result=%h npc=%h, required no write-back",
                         cyc, bus.wb_dest, bus.wb_result, bus.wb_npc);
            end else begin
                e = sb.pop_front();
                if (bus.wb_dest !== e.dest || bus.wb_result !== e.res || bus.wb_npc !== e.npc ||
                    bus.wb_pc_change !== e.chg || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL wb_compare: got cyc=%0d dest=%0d res=%h npc=%h chg=%b, required cyc=%0d dest=%0d res=%h npc=%h chg=%b",
                             cyc, bus.wb_dest, bus.wb_result, bus.wb_npc, bus.wb_pc_change,
                             e.cyc, e.dest, e.res, e.npc, e.chg);
                end
            end
        end
    end

    function automatic vec_t mk(input logic [4:0] op, input logic jen, input logic ben,
                                input logic [31:0] op1, input logic [31:0] op2, input logic [31:0] imm,
                                input logic [31:0] pc, input logic [31:0] res, input logic [31:0] npc,
                                input logic chg);
        vec_t v;
        v.op = op; v.jen = jen; v.ben = ben; v.op1 = op1; v.op2 = op2; v.imm = imm;
        v.pc = pc; v.res = res; v.npc = npc; v.chg = chg;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic idle();
        bus.in_valid   = 1'b0;
        bus.in_alu_op  = '0;
        bus.in_jen     = 1'b0;
        bus.in_ben     = 1'b0;
        bus.in_op1     = '0;
        bus.in_op2     = '0;
        bus.in_imm     = '0;
        bus.in_pc      = '0;
        bus.in_qj      = '0;
        bus.in_qk      = '0;
        bus.in_dest    = '0;
        bus.cdb_valid  = 1'b0;
        bus.cdb_dest   = '0;
        bus.cdb_result = '0;
        flush          = 1'b0;
        reset          = 1'b1;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic set_disp(input logic [4:0] op, input logic jen, input logic ben,
                            input logic [31:0] op1, input logic [31:0] op2, input logic [31:0] imm,
                            input logic [31:0] pc, input logic [3:0] qj, input logic [3:0] qk,
                            input logic [3:0] dest);
        bus.in_valid  = 1'b1;
        bus.in_alu_op = op;
        bus.in_jen    = jen;
        bus.in_ben    = ben;
        bus.in_op1    = op1;
        bus.in_op2    = op2;
        bus.in_imm    = imm;
        bus.in_pc     = pc;
        bus.in_qj     = qj;
        bus.in_qk     = qk;
        bus.in_dest   = dest;
    endtask

    task automatic set_cdb(input logic [3:0] tag, input logic [31:0] val);
        bus.cdb_valid  = 1'b1;
        bus.cdb_dest   = tag;
        bus.cdb_result = val;
    endtask

    task automatic expect_wb(input logic [3:0] dest, input logic [31:0] res, input logic [31:0] npc,
                             input logic chg, input int at_cyc);
        exp_t e;
        e.dest = dest; e.res = res; e.npc = npc; e.chg = chg; e.cyc = at_cyc;
        sb.push_back(e);
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        while (sb.size() != 0 && n < max_cycles) begin
            step();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results still pending, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_cleared(input string tag);
        @(negedge clock);
        chk({tag, "_wb_valid"},  32'(bus.wb_valid), 32'd0);
        chk({tag, "_wb_dest"},   32'(bus.wb_dest), 32'd0);
        chk({tag, "_wb_result"}, bus.wb_result, 32'd0);
        chk({tag, "_wb_npc"},    bus.wb_npc, 32'd0);
        chk({tag, "_wb_chg"},    32'(bus.wb_pc_change), 32'd0);
        chk({tag, "_out_ready"}, 32'(bus.out_ready), 32'd1);
    endtask

    // Three waiting entries plus one op sitting in the wb register, then flush or reset.
    task automatic kill_test(input logic use_reset);
        int base = cyc;
        for (int i = 0; i < 3; i++) begin
            set_disp(5'd0, 1'b0, 1'b0, 32'd0, 32'd1, 32'd0, 32'hA00, 4'd7, 4'd0, 4'(i + 1));
            step();
        end
        set_disp(5'd0, 1'b0, 1'b0, 32'd1, 32'd2, 32'd0, 32'hA10, 4'd0, 4'd0, 4'd4);
        expect_wb(4'd4, 32'd3, 32'hA14, 1'b0, base + 5);
        step();
        step();
        if (use_reset) reset = 1'b0;
        else           flush = 1'b1;
        step();
        check_cleared(use_reset ? "rst_mid" : "flush");
        set_cdb(4'd7, 32'd5);
        step();
        repeat (5) step();
        base = cyc;
        set_disp(5'd4, 1'b0, 1'b0, 32'hF0, 32'h0F, 32'd0, 32'hB00, 4'd0, 4'd0, 4'd6);
        expect_wb(4'd6, 32'hFF, 32'hB04, 1'b0, base + 2);
        step();
        drain(10);
    endtask

    initial begin
        int base;
        vt.push_back(mk(5'd0,  1'b0, 1'b0, 32'd5,        32'd7,  32'd0,        32'h1000, 32'd12,       32'h1004, 1'b0));
        vt.push_back(mk(5'd8,  1'b0, 1'b0, 32'd5,        32'd7,  32'd0,        32'h1010, 32'hFFFFFFFE, 32'h1014, 1'b0));
        vt.push_back(mk(5'd1,  1'b0, 1'b0, 32'd1,        32'd33, 32'd0,        32'h1020, 32'd2,        32'h1024, 1'b0));
        vt.push_back(mk(5'd2,  1'b0, 1'b0, 32'hFFFFFFFF, 32'd2,  32'd0,        32'h1030, 32'd1,        32'h1034, 1'b0));
        vt.push_back(mk(5'd3,  1'b0, 1'b0, 32'hFFFFFFFF, 32'd2,  32'd0,        32'h1040, 32'd0,        32'h1044, 1'b0));
        vt.push_back(mk(5'd4,  1'b0, 1'b0, 32'hF0,       32'hFF, 32'd0,        32'h1050, 32'h0F,       32'h1054, 1'b0));
        vt.push_back(mk(5'd5,  1'b0, 1'b0, 32'h80000000, 32'd4,  32'd0,        32'h1060, 32'h08000000, 32'h1064, 1'b0));
        vt.push_back(mk(5'd13, 1'b0, 1'b0, 32'h80000000, 32'd4,  32'd0,        32'h1070, 32'hF8000000, 32'h1074, 1'b0));
        vt.push_back(mk(5'd6,  1'b0, 1'b0, 32'hF0,       32'h0F, 32'd0,        32'h1080, 32'hFF,       32'h1084, 1'b0));
        vt.push_back(mk(5'd7,  1'b0, 1'b0, 32'hF0,       32'h3C, 32'd0,        32'h1090, 32'h30,       32'h1094, 1'b0));
        vt.push_back(mk(5'd1,  1'b0, 1'b1, 32'd1,        32'd2,  32'h20,       32'h100,  32'd0,        32'h120,  1'b1));
        vt.push_back(mk(5'd0,  1'b0, 1'b1, 32'd1,        32'd2,  32'h20,       32'h100,  32'd0,        32'h104,  1'b0));
        vt.push_back(mk(5'd4,  1'b0, 1'b1, 32'hFFFFFFFF, 32'd1,  32'h40,       32'h200,  32'd0,        32'h240,  1'b1));
        vt.push_back(mk(5'd5,  1'b0, 1'b1, 32'hFFFFFFFF, 32'd1,  32'h40,       32'h200,  32'd0,        32'h204,  1'b0));
        vt.push_back(mk(5'd6,  1'b0, 1'b1, 32'hFFFFFFFF, 32'd1,  32'h40,       32'h200,  32'd0,        32'h204,  1'b0));
        vt.push_back(mk(5'd7,  1'b0, 1'b1, 32'hFFFFFFFF, 32'd1,  32'h40,       32'h200,  32'd0,        32'h240,  1'b1));
        vt.push_back(mk(5'd0,  1'b0, 1'b1, 32'd3,        32'd3,  32'hFFFFFFF0, 32'h500,  32'd0,        32'h4F0,  1'b1));
        vt.push_back(mk(5'd0,  1'b1, 1'b0, 32'h203,      32'd0,  32'd0,        32'h300,  32'h304,      32'h202,  1'b1));
        vt.push_back(mk(5'd0,  1'b1, 1'b0, 32'h400,      32'd0,  32'h10,       32'h400,  32'h404,      32'h410,  1'b1));

        idle();
        reset = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        check_cleared("reset");

        // Ready ops, one per cycle: each must write back exactly two cycles after dispatch.
        for (int i = 0; i < vt.size(); i++) begin
            set_disp(vt[i].op, vt[i].jen, vt[i].ben, vt[i].op1, vt[i].op2, vt[i].imm, vt[i].pc,
                     4'd0, 4'd0, 4'((i % 7) + 1));
            expect_wb(4'((i % 7) + 1), vt[i].res, vt[i].npc, vt[i].chg, cyc + 2);
            step();
        end
        drain(10);

        // CDB wakeup three cycles after dispatch.
        base = cyc;
        set_disp(5'd8, 1'b0, 1'b0, 32'hDEAD, 32'd1, 32'd0, 32'h700, 4'd2, 4'd0, 4'd4);
        expect_wb(4'd4, 32'd9, 32'h704, 1'b0, base + 5);
        step(); step(); step();
        set_cdb(4'd2, 32'd10);
        step();
        drain(10);

        // Dispatch bypass from a same-cycle CDB broadcast.
        base = cyc;
        set_disp(5'd8, 1'b0, 1'b0, 32'hDEAD, 32'd1, 32'd0, 32'h710, 4'd2, 4'd0, 4'd4);
        set_cdb(4'd2, 32'd10);
        expect_wb(4'd4, 32'd9, 32'h714, 1'b0, base + 2);
        step();
        drain(10);

        // Both operands waiting on the same tag.
        base = cyc;
        set_disp(5'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'h720, 4'd6, 4'd6, 4'd5);
        expect_wb(4'd5, 32'd42, 32'h724, 1'b0, base + 3);
        step();
        set_cdb(4'd6, 32'd21);
        step();
        drain(10);

        // Chained forwarding through the unit's own write-back.
        base = cyc;
        set_disp(5'd0, 1'b0, 1'b0, 32'd5, 32'd7, 32'd0, 32'h800, 4'd0, 4'd0, 4'd1);
        expect_wb(4'd1, 32'd12, 32'h804, 1'b0, base + 2);
        step();
        set_disp(5'd4, 1'b0, 1'b0, 32'd0, 32'hF, 32'd0, 32'h810, 4'd1, 4'd0, 4'd2);
        expect_wb(4'd2, 32'd3, 32'h814, 1'b0, base + 4);
        step();
        drain(10);

        // CDB and own write-back carry the same tag: the CDB value must be taken.
        base = cyc;
        set_disp(5'd0, 1'b0, 1'b0, 32'd5, 32'd7, 32'd0, 32'h900, 4'd0, 4'd0, 4'd3);
        expect_wb(4'd3, 32'd12, 32'h904, 1'b0, base + 2);
        step();
        set_disp(5'd0, 1'b0, 1'b0, 32'd0, 32'd1, 32'd0, 32'h910, 4'd3, 4'd0, 4'd5);
        expect_wb(4'd5, 32'd101, 32'h914, 1'b0, base + 4);
        step();
        set_cdb(4'd3, 32'd100);
        step();
        drain(10);

        // Fill all entries, reject a fifth, then release them in index order.
        base = cyc;
        for (int i = 0; i < 4; i++) begin
            set_disp(5'd0, 1'b0, 1'b0, 32'd0, 32'(i), 32'd0, 32'h600 + 32'(4 * i), 4'd5, 4'd0, 4'(i + 1));
            expect_wb(4'(i + 1), 32'd100 + 32'(i), 32'h604 + 32'(4 * i), 1'b0, base + 7 + i);
            @(negedge clock);
            chk("full_ready_filling", 32'(bus.out_ready), 32'd1);
            step();
        end
        set_disp(5'd0, 1'b0, 1'b0, 32'd1, 32'd1, 32'd0, 32'h6F0, 4'd0, 4'd0, 4'd7);
        @(negedge clock);
        chk("full_ready_low", 32'(bus.out_ready), 32'd0);
        step();
        set_cdb(4'd5, 32'd100);
        @(negedge clock);
        chk("full_ready_wake", 32'(bus.out_ready), 32'd0);
        step();
        @(negedge clock);
        chk("full_ready_issue", 32'(bus.out_ready), 32'd0);
        step();
        @(negedge clock);
        chk("full_ready_freed", 32'(bus.out_ready), 32'd1);
        step();
        drain(10);

        kill_test(1'b0);
        kill_test(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end
endmodule
